// File: rtl/display_scheduler.sv
// Chooses time/date view and alarm blanking for the eight-digit display.
// Optional alarm flashing is enabled by defining DISP_SCHED_ALARM_EN.
module display_scheduler #(
  parameter int unsigned AUTO_PERIOD = 30,
  parameter int unsigned DATE_HOLD   = 5,
  parameter int unsigned BTN_HOLD    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] second_in,
  input  logic       btn_date,
  input  logic       alarm_active,
  output logic       display_year,
  output logic       blank,
  output logic [1:0] state_out
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SEC_W = 6;

  typedef enum logic [1:0] {
    S_TIME      = 2'd0,
    S_DATE_AUTO = 2'd1,
    S_DATE_BTN  = 2'd2,
    S_ALARM     = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SEC_W-1:0]   prev_sec;
  logic               seeded;
  logic [CNT_W-1:0]   sec_cnt;
  logic [CNT_W-1:0]   sec_cnt_nxt;
  logic               tick;
  logic               restart;
  logic               alarm_owns;

  // One tick per observed change of the seconds value; first cycle only seeds.
  assign tick = seeded && (second_in != prev_sec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seeded   <= 1'b0;
      prev_sec <= '0;
    end else begin
      seeded   <= 1'b1;
      prev_sec <= second_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_TIME;
      sec_cnt <= '0;
    end else begin
      state   <= state_nxt;
      sec_cnt <= sec_cnt_nxt;
    end
  end

  // Priority: alarm, alarm release, button, then per-state timeouts.
  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    alarm_owns = 1'b0;
`ifdef DISP_SCHED_ALARM_EN
    if (state == S_ALARM) begin
      alarm_owns = 1'b1;
      if (!alarm_active) state_nxt = S_TIME;
    end else if (alarm_active) begin
      alarm_owns = 1'b1;
      state_nxt  = S_ALARM;
    end
`endif
    if (!alarm_owns) begin
      if (btn_date) begin
        state_nxt = S_DATE_BTN;
        restart   = 1'b1;
      end else if (tick) begin
        case (state)
          S_TIME:      if (sec_cnt == CNT_W'(AUTO_PERIOD - 1)) state_nxt = S_DATE_AUTO;
          S_DATE_AUTO: if (sec_cnt == CNT_W'(DATE_HOLD - 1))   state_nxt = S_TIME;
          S_DATE_BTN:  if (sec_cnt == CNT_W'(BTN_HOLD - 1))    state_nxt = S_TIME;
          default:     state_nxt = state;
        endcase
      end
    end
  end

  // A tick on the same edge as a transition is not credited to the new state.
  always_comb begin
    sec_cnt_nxt = sec_cnt;
    if (restart || (state_nxt != state)) begin
      sec_cnt_nxt = '0;
    end else if (tick) begin
      sec_cnt_nxt = sec_cnt + CNT_W'(1);
    end
  end

`ifdef DISP_SCHED_ALARM_EN
  logic blank_nxt;

  // Blank starts lit on alarm entry and flips once per second while ringing.
  always_comb begin
    blank_nxt = 1'b0;
    if ((state == S_ALARM) && (state_nxt == S_ALARM)) begin
      blank_nxt = tick ? ~blank : blank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank <= 1'b0;
    else        blank <= blank_nxt;
  end
`else
  logic unused_alarm;
  assign unused_alarm = alarm_active;
  assign blank        = 1'b0;
`endif

  assign display_year = (state == S_DATE_AUTO) || (state == S_DATE_BTN);
  assign state_out    = state;

endmodule
